// File: rtl/divider.sv
// divider: sequential radix-2 restoring divider for the MIPS ALU.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned,
// producing a WIDTH-bit quotient and remainder that truncate toward zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   signed_op  1 = two's-complement divide, 0 = unsigned
//   A          2*WIDTH-bit dividend
//   B          WIDTH-bit divisor
//   Quotient   WIDTH-bit quotient (low bits of the full quotient)
//   Remainder  WIDTH-bit remainder, sign follows the dividend
//   busy       high from the accept edge until the result edge
//   done       one-cycle pulse when results are valid
//   overflow   quotient not representable in WIDTH bits
//   div_zero   divisor was zero
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results and flags hold
// CALC  | 2*WIDTH shift/subtract iterations on the magnitudes
// FIX   | apply signs, evaluate overflow, register results, pulse done
module divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     Quotient,
    output logic [WIDTH-1:0]     Remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 div_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] Q_HALF = {{(DW-1){1'b0}}, 1'b1} << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    // Holds |A| on entry to CALC; dividend bits shift out of the top while
    // quotient bits shift in at the bottom. On the div-zero path it holds raw A.
    logic [DW-1:0]    dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] bmag;
    logic             sgn;
    logic             sign_a;
    logic             sign_b;
    logic             dz;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf;
    logic             b_zero;
    logic [DW-1:0]    a_mag;
    logic [WIDTH-1:0] b_mag_in;

    // Partial remainder is always < |B|, so the shifted trial value needs
    // WIDTH+1 bits; the difference's MSB is the borrow (trial < |B|).
    always_comb begin
        trial   = {rem, dvd[DW-1]};
        diff    = trial - {1'b0, bmag};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_comb begin
        b_zero   = (B == '0);
        a_mag    = (signed_op && A[DW-1]) ? -A : A;
        b_mag_in = (signed_op && B[WIDTH-1]) ? -B : B;
    end

    // Low bits of a negated 2W-bit value equal the negation of its low bits.
    always_comb begin
        q_neg = sgn & (sign_a ^ sign_b);
        r_neg = sgn & sign_a;
        q_fix = q_neg ? -dvd[WIDTH-1:0] : dvd[WIDTH-1:0];
        r_fix = r_neg ? -rem : rem;
        if (sgn) begin
            ovf = q_neg ? (dvd > Q_HALF) : (dvd >= Q_HALF);
        end else begin
            ovf = |dvd[DW-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvd       <= '0;
            rem       <= '0;
            bmag      <= '0;
            sgn       <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dz        <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                        sgn      <= signed_op;
                        sign_a   <= signed_op & A[DW-1];
                        sign_b   <= signed_op & B[WIDTH-1];
                        bmag     <= b_mag_in;
                        dvd      <= b_zero ? A : a_mag;
                        rem      <= '0;
                        dz       <= b_zero;
                        cnt      <= CW'(DW - 1);
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= {dvd[DW-2:0], ge};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dz) begin
                        Quotient  <= '1;
                        Remainder <= dvd[WIDTH-1:0];
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else begin
                        Quotient  <= q_fix;
                        Remainder <= r_fix;
                        overflow  <= ovf;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] A;
    logic [15:0] B;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .A         (A),
        .B         (B),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble inputs after acceptance, and count edges
    // from the accept edge to the done pulse (-1 if it never comes).
    task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                         input logic s, output int lat);
        @(negedge clk);
        A = a; B = b; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 32'hDEAD_BEEF; B = 16'h0000; signed_op = ~s;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
        #12;
        chk("reset_outputs", {Quotient, Remainder}, 32'h0);
        chk("reset_flags", {28'h0, busy, done, overflow, div_zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat;
        do_op(32'd100000, 16'd300, 1'b0, lat);
        chk("unsigned_latency", lat, 33);
        chk("unsigned_q", Quotient, 16'd333);
        chk("unsigned_r", Remainder, 16'd100);
        chk("unsigned_flags", {30'h0, overflow, div_zero}, 32'h0);
        chk("unsigned_busy_low", busy, 1'b0);
        do_op(32'h0001_0000, 16'h0001, 1'b0, lat);
        chk("unsigned_ovf_q", Quotient, 16'h0000);
        chk("unsigned_ovf_flag", overflow, 1'b1);
    endtask

    task automatic test_signed;
        int lat;
        do_op(32'hFFFF_FFF9, 16'h0002, 1'b1, lat);
        chk("signed_neg_q", Quotient, 16'hFFFD);
        chk("signed_neg_r", Remainder, 16'hFFFF);
        chk("signed_neg_ovf", overflow, 1'b0);
        do_op(32'hFFFF_FFF9, 16'hFFFE, 1'b1, lat);
        chk("signed_pos_q", Quotient, 16'h0003);
        chk("signed_pos_r", Remainder, 16'hFFFF);
    endtask

    task automatic test_range;
        int lat;
        do_op(32'hFFFF_8000, 16'h0001, 1'b1, lat);
        chk("min_q", Quotient, 16'h8000);
        chk("min_ovf", overflow, 1'b0);
        do_op(32'h0000_8000, 16'h0001, 1'b1, lat);
        chk("pos_edge_q", Quotient, 16'h8000);
        chk("pos_edge_ovf", overflow, 1'b1);
        do_op(32'hFFFF_8000, 16'hFFFF, 1'b1, lat);
        chk("negneg_ovf", overflow, 1'b1);
        do_op(32'h8000_0000, 16'h0001, 1'b1, lat);
        chk("mindvd_ovf", overflow, 1'b1);
        chk("mindvd_q", Quotient, 16'h0000);
    endtask

    task automatic test_div_zero;
        int lat;
        do_op(32'h1234_5678, 16'h0000, 1'b0, lat);
        chk("dz_latency", lat, 1);
        chk("dz_flag", div_zero, 1'b1);
        chk("dz_ovf", overflow, 1'b0);
        chk("dz_q", Quotient, 16'hFFFF);
        chk("dz_r", Remainder, 16'h5678);
        // Next accept clears flags but holds old results.
        @(negedge clk);
        A = 32'd10; B = 16'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_clear_flags", {30'h0, div_zero, done}, 32'h0);
        chk("accept_hold_q", Quotient, 16'hFFFF);
        chk("accept_busy", busy, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("after_dz_q", Quotient, 16'd3);
        chk("after_dz_r", Remainder, 16'd1);
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        A = 32'd50; B = 16'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        // Held through the done edge; must only be taken the clock after.
        A = 32'd9; B = 16'd3; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_seen", (lat > 0), 1'b1);
        chk("b2b_first_q", Quotient, 16'd7);
        chk("b2b_first_r", Remainder, 16'd1);
        chk("b2b_busy_on_done", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_accept", busy, 1'b1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_second_latency", lat, 33);
        chk("b2b_second_q", Quotient, 16'd3);
        chk("b2b_second_r", Remainder, 16'd0);
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        do_op(32'd100, 16'd7, 1'b0, lat);
        @(negedge clk);
        A = 32'd100000; B = 16'd300; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {Quotient, Remainder}, 32'h0);
        chk("midrst_flags", {28'h0, busy, done, overflow, div_zero}, 32'h0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrst_no_done", seen, 0);
        do_op(32'd100000, 16'd300, 1'b0, lat);
        chk("midrst_fresh_latency", lat, 33);
        chk("midrst_fresh_q", Quotient, 16'd333);
        chk("midrst_fresh_r", Remainder, 16'd100);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_range();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
